// File: rtl/emu_sram_pkg.sv
// Shared types and helpers for the emu_sram 1RW+1R block RAM emulation model.
// lane_merge works on a fixed maximum width so one function serves every instance size.
package emu_sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_e;

    localparam int unsigned MAX_DW      = 1024;
    localparam int unsigned MAX_DW_W    = 10;
    localparam int unsigned MAX_LANES   = 128;
    localparam int unsigned MAX_LANES_W = 7;

    // Lanes with mask set take new_word, all others keep old_word; bits above data_width pass old_word.
    function automatic logic [MAX_DW-1:0] lane_merge(
        input logic [MAX_DW-1:0]    old_word,
        input logic [MAX_DW-1:0]    new_word,
        input logic [MAX_LANES-1:0] mask,
        input int unsigned          num_wmasks,
        input int unsigned          data_width
    );
        logic [MAX_DW-1:0]      res;
        logic [MAX_LANES_W-1:0] lane;
        int unsigned            lw;
        res = old_word;
        lw  = data_width / num_wmasks;
        for (int unsigned b = 0; b < MAX_DW; b++) begin
            lane = MAX_LANES_W'(b / lw);
            if ((b < data_width) && mask[lane]) begin
                res[MAX_DW_W'(b)] = new_word[MAX_DW_W'(b)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/emu_sram_clear_seq.sv
// Post-reset clear sequencer: walks every address once writing zero, then reports ready.
// init_busy_o is registered and stays high through reset and the whole clear walk.
module emu_sram_clear_seq
    import emu_sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o,
    output logic                  ready_o,
    output logic                  init_busy_o
);

    sram_state_e           state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic                  busy_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
                    if (clr_addr_q == '1) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end
                end
                READY: begin
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we_o    = (state_q == CLEAR) && rst_ni;
    assign clr_addr_o  = clr_addr_q;
    assign ready_o     = (state_q == READY);
    assign init_busy_o = busy_q;

endmodule

// File: rtl/emu_sram_1rw1r.sv
// Functional emulation of the fabric 1RW+1R block RAM with per-lane write masks.
// Port 0 reads/writes, port 1 reads; both are registered with one cycle of latency.
module emu_sram_1rw1r
    import emu_sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned NUM_WMASKS     = 4,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter bit          WRITE_THROUGH  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  init_busy
);

    localparam int unsigned RAM_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
    logic [DATA_WIDTH-1:0] dout1_q, dout1_d;

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  ready;

    emu_sram_clear_seq #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk_i      (CLK),
        .rst_ni     (resetn),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .ready_o    (ready),
        .init_busy_o(init_busy)
    );

    logic port_en, wr0, rd0, rd1, collide;
    assign port_en = ready && resetn;
    assign wr0     = port_en && !csb0 && !web0;
    assign rd0     = port_en && !csb0 && web0;
    assign rd1     = port_en && !csb1;
    assign collide = wr0 && (addr0 == addr1);

    // Words are widened to the package maximum so one lane_merge serves all sizes.
    logic [MAX_DW-1:0]     old_ext, new_ext, merged_ext;
    logic [MAX_LANES-1:0]  mask_ext;
    logic [DATA_WIDTH-1:0] wr_word;
    logic                  unused_merge_hi;

    always_comb begin
        old_ext                   = '0;
        new_ext                   = '0;
        mask_ext                  = '0;
        old_ext[DATA_WIDTH-1:0]   = mem_q[addr0];
        new_ext[DATA_WIDTH-1:0]   = din0;
        mask_ext[NUM_WMASKS-1:0]  = wmask0;
        merged_ext = lane_merge(old_ext, new_ext, mask_ext, NUM_WMASKS, DATA_WIDTH);
        wr_word    = merged_ext[DATA_WIDTH-1:0];
    end

    assign unused_merge_hi = ^merged_ext;

    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr0) begin
            mem_q[addr0] <= wr_word;
        end
    end

    always_comb begin
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        if (rd0) begin
            dout0_d = mem_q[addr0];
        end
        if (rd1) begin
            dout1_d = (WRITE_THROUGH && collide) ? wr_word : mem_q[addr1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
        end
    end

    assign dout0 = dout0_q;
    assign dout1 = dout1_q;

endmodule

// File: doc/emu_sram_1rw1r.md
Name: emu_sram_1rw1r

Overview:
Functional emulation model of the fabric's 1RW+1R block RAM. It replaces the zero-output stub used in FPGA emulation builds so that BRAM-using user designs behave correctly on the emulation board. It is parametrised in width, depth and write-mask granularity. Both ports run on the single fabric clock. An optional post-reset clear sequencer gives the array deterministic contents.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 8, address bits; RAM_DEPTH = 2**ADDR_WIDTH
NUM_WMASKS, 4, write-mask lanes; DATA_WIDTH must be divisible by it; lane width LW = DATA_WIDTH/NUM_WMASKS
CLEAR_ON_RESET, 1, 1 = zero all words after reset release; 0 = skip clear, contents retained/undefined
WRITE_THROUGH, 0, port-1 same-address collision: 0 = old data, 1 = newly written data

Ports:
CLK  in  1  fabric clock, all logic rising-edge
resetn  in  1  synchronous active-low reset
csb0  in  1  port 0 chip select, active low
web0  in  1  port 0 write enable, active low
wmask0  in  NUM_WMASKS  per-lane write enable, active high
addr0  in  ADDR_WIDTH  port 0 address
din0  in  DATA_WIDTH  port 0 write data
dout0  out  DATA_WIDTH  port 0 registered read data
csb1  in  1  port 1 chip select, active low
addr1  in  ADDR_WIDTH  port 1 address
dout1  out  DATA_WIDTH  port 1 registered read data
init_busy  out  1  high while in reset or clearing; accesses are ignored

Behaviour:
- resetn low at a CLK edge: dout0 = 0, dout1 = 0, init_busy = 1, FSM -> CLEAR with clr_addr = 0 (or READY if CLEAR_ON_RESET=0). Memory array is not reset directly.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle with resetn high writes 0 to mem[clr_addr] and increments clr_addr. On clr_addr == RAM_DEPTH-1, that word is written and the FSM goes to READY. Clear therefore takes exactly RAM_DEPTH cycles after release.
  - init_busy = 1 in CLEAR, 0 in READY, registered.
- Reset during CLEAR restarts the clear from address 0. Reset during READY enters CLEAR again.
- In CLEAR, all port inputs are ignored: no writes, dout0/dout1 hold 0.
- READY, port 0:
  - csb0=0, web0=1: dout0 <= mem[addr0]; latency 1 cycle.
  - csb0=0, web0=0: for each lane i with wmask0[i]=1, mem[addr0][i*LW +: LW] <= din0 lane i. Other lanes are unchanged. dout0 holds its previous value.
  - wmask0 = 0 during a write: no change to memory.
- READY, port 1: csb1=0 gives dout1 <= mem[addr1], latency 1 cycle.
- Deselected port (csb=1): its dout holds.
- Collision (port 0 write and port 1 read, same address, same cycle):
  - WRITE_THROUGH=0: dout1 = pre-write word.
  - WRITE_THROUGH=1: dout1 = merged word (masked lanes from din0, others old).
  - The memory update is identical in both modes.
- Port 0 read and port 1 read of the same address: both return the same word.
- Addresses cover the full RAM_DEPTH; no out-of-range case exists.

Decomposition:
- Package emu_sram_pkg:
  - state enum {CLEAR, READY}
  - function lane_merge(old, new, mask, NUM_WMASKS) used for both the write and the write-through path
- Sub-module emu_sram_clear_seq: FSM, clr_addr counter and init_busy, parametrised by ADDR_WIDTH and CLEAR_ON_RESET. It outputs the clear write enable and clear address to the array.

Test Plan:
1. Defaults. Hold resetn low 3 cycles, then release -> init_busy = 1 for exactly 256 cycles, then 0. Port 1 read of addr 0xFF -> dout1 = 0x00000000 one cycle later.
2. Port 0 write 0xDEADBEEF to addr 0x10 with wmask0 = 4'hF, then read addr 0x10 -> dout0 = 0xDEADBEEF on the cycle after the read; dout0 unchanged during the write cycle.
3. Partial write 0x11223344 to addr 0x10 with wmask0 = 4'b0101 -> next read returns 0xDE22BE44. A write with wmask0 = 0 leaves 0xDE22BE44 intact.
4. Collision: addr 0x20 holds 0. Write 0xCAFEF00D there while port 1 reads 0x20 in the same cycle.
   - WRITE_THROUGH=0 -> dout1 = 0x00000000.
   - WRITE_THROUGH=1 -> dout1 = 0xCAFEF00D.
   - Next-cycle reads on both ports return 0xCAFEF00D in both modes.
5. Reassert resetn low at clear cycle 100, release -> init_busy stays 1 for a further full 256 cycles. A write of 0x5 to addr 0x05 issued during clear is ignored; a later read returns 0.
6. Deselect hold: read addr 0x10 on both ports, then set csb0 = csb1 = 1 and change the addresses -> dout0/dout1 keep their prior values for 5 cycles.
